apb_uart_sequencer: RTL and testbench
=====================================

# apb_uart_sequencer

APB master that owns the APB port of one UART peripheral and sequences it autonomously. After reset it programs the baud divider and control register, then loops: poll status, drain received bytes into a stream output, push stream-input bytes into the TX buffer, clear overrun flags. It sits between a byte-stream client (DMA, debug bridge, test core) and the UART, so the client never issues APB cycles itself.

## Interface
- `BAUD_DIV`, 20'd434; value written to BAUDDIV (0x10) at init; must be ≥ 32
- `CTRL_INIT`, 4'b0011; value written to CTRL (0x00) at init (RX+TX enable, no IRQs)
- `PCLK` input 1: clock. One clock for the whole block.
- `PRESET` input 1: reset, synchronous, active-high.
- `M_PSEL` output 1: APB select to UART
- `M_PENABLE` output 1: APB enable
- `M_PWRITE` output 1: APB write
- `M_PADDR` output 6: APB word address [7:2]
- `M_PWDATA` output 32: APB write data
- `M_PRDATA` input 32: APB read data
- `M_PREADY` input 1: APB ready
- `tx_data` input 8: byte to transmit
- `tx_valid` input 1: tx_data valid
- `tx_ready` output 1: byte accepted (one-cycle pulse)
- `rx_data` output 8: received byte
- `rx_valid` output 1: rx_data valid, held until taken
- `rx_ready` input 1: client takes rx_data
- `init_done` output 1: init writes complete
- `rx_ovr` output 1: sticky, UART RX overrun seen
- `tx_ovr` output 1: sticky, UART TX overrun seen
- `err_clr` input 1: clears rx_ovr/tx_ovr

## Operation
- APB transfer: setup cycle (PSEL=1, PENABLE=0), then access cycles (PSEL=1, PENABLE=1) until PREADY=1. Read data is sampled on the access cycle where PREADY=1. The next setup may follow immediately, with no idle cycle.
- FSM states: INIT_BAUD → INIT_CTRL → POLL → one of {RD_RXD, CLR_STAT, WR_TXD}, or back to POLL directly.
  - INIT_BAUD: write BAUDDIV.
  - INIT_CTRL: write CTRL.
  - POLL: read STAT (0x04) and register it.
  - Decision, fixed priority:
    1. RD_RXD if STAT[1]=1 and the RX holding register is empty.
    2. CLR_STAT if STAT[3:2]≠0.
    3. WR_TXD if tx_valid=1 and STAT[0]=0.
    4. Otherwise POLL again.
- RD_RXD: read 0x0C. PRDATA[7:0] loads the holding register; rx_valid rises the next cycle.
- CLR_STAT: write 0x04 with PWDATA = {28'b0, STAT[3:2], 2'b00}. rx_ovr |= STAT[3], tx_ovr |= STAT[2].
- WR_TXD: write 0x08 with PWDATA = {24'b0, tx_data}. tx_ready=1 on the completing access cycle.
- RX holding register:
  - Cleared when rx_valid & rx_ready.
  - While full, RX is not serviced. A resulting UART overrun surfaces through CLR_STAT.
- Flags: err_clr clears rx_ovr/tx_ovr. If a set and err_clr occur in the same cycle, set wins.
- Unused PWDATA bits are 0. M_PWDATA = 0 and M_PADDR = 0 when PSEL=0.

## Timing
- Reset values: M_PSEL=0, M_PENABLE=0, M_PWRITE=0, M_PADDR=0, M_PWDATA=0, tx_ready=0, rx_valid=0, rx_data=0, init_done=0, rx_ovr=0, tx_ovr=0. FSM returns to INIT_BAUD.
- First setup cycle occurs on the first edge after PRESET deasserts.
- With PREADY tied 1, each transfer is 2 cycles:
  - init_done rises in cycle 5 after reset release.
  - POLL+action loop is 4 cycles.
  - Minimum tx_valid→tx_ready latency is 4 cycles (POLL 2 + WR setup 1 + access 1).
- Decision uses the STAT value registered at POLL completion and the holding-register state at that edge.
- tx_data must be held stable while tx_valid=1. It is sampled at the WR_TXD setup cycle.
- PREADY low stretches the access phase. All outputs hold their values.
- PRESET asserted mid-transfer: PSEL/PENABLE drop at the next edge, the transfer is abandoned, and init reruns.

## Structure
- Shared package `apb_uart_pkg`:
  - UART word addresses: CTRL=6'h00, STAT=6'h01, TXD=6'h02, RXD=6'h03, BAUDDIV=6'h04, INTCLR=6'h05
  - STAT bit indices
  - Sequencer state enum
- One sub-module, `apb_xfer_engine`:
  - Accepts req/addr/write/wdata.
  - Drives the two-phase APB handshake.
  - Returns done plus rdata.
  - The top-level FSM owns policy only.

## Test plan
- Reset release with PREADY=1: APB log shows W 0x10=434 then W 0x00=3; init_done=1 at cycle 5; STAT reads begin.
- tx_valid with tx_data=0x55, STAT[0]=0: W 0x08=0x55 follows the POLL; one tx_ready pulse; UART TXD emits 0x55 at the programmed baud.
- UART receives 0xA3 while rx_ready=0: rx_valid=1, rx_data=0xA3. A second byte, 0x3C, is not read, and the UART overrun follows. Expect W 0x04=0x8, rx_ovr=1; then rx_ready → next read delivers 0x3C.
- RX full and tx_valid in the same POLL: RD_RXD is performed first; WR_TXD follows in the next loop.
- PREADY held low 3 cycles during WR_TXD: outputs stable, tx_ready only on the completing cycle.
- PRESET pulsed during RD_RXD access: PSEL=0 next cycle, rx_valid=0, init sequence repeats.

Source files
------------

// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB UART sequencer: UART register map,
// STAT bit positions and the sequencer state encoding.
package apb_uart_pkg;

  // UART register word addresses (byte address >> 2)
  localparam logic [5:0] A_CTRL    = 6'h00;
  localparam logic [5:0] A_STAT    = 6'h01;
  localparam logic [5:0] A_TXD     = 6'h02;
  localparam logic [5:0] A_RXD     = 6'h03;
  localparam logic [5:0] A_BAUDDIV = 6'h04;
  localparam logic [5:0] A_INTCLR  = 6'h05;

  // STAT register bits
  localparam int STAT_TXFULL  = 0;
  localparam int STAT_RXAVAIL = 1;
  localparam int STAT_TXOVR   = 2;
  localparam int STAT_RXOVR   = 3;

  typedef enum logic [2:0] {
    ST_INIT_BAUD,
    ST_INIT_CTRL,
    ST_POLL,
    ST_RD_RXD,
    ST_CLR_STAT,
    ST_WR_TXD
  } seq_state_e;

endpackage

// File: rtl/apb_xfer_engine.sv
// Two-phase APB master handshake. A new request is launched whenever the
// bus is idle or the current transfer completes, so back-to-back transfers
// need no idle cycle. Address/data are dropped to zero when the bus idles.
module apb_xfer_engine (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        i_req,
  input  logic [5:0]  i_addr,
  input  logic        i_write,
  input  logic [31:0] i_wdata,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        M_PSEL,
  output logic        M_PENABLE,
  output logic        M_PWRITE,
  output logic [5:0]  M_PADDR,
  output logic [31:0] M_PWDATA,
  input  logic [31:0] M_PRDATA,
  input  logic        M_PREADY
);

  logic        r_psel, r_penable, r_pwrite;
  logic [5:0]  r_paddr;
  logic [31:0] r_pwdata;

  assign o_done    = r_psel & r_penable & M_PREADY;
  assign o_rdata   = M_PRDATA;
  assign M_PSEL    = r_psel;
  assign M_PENABLE = r_penable;
  assign M_PWRITE  = r_pwrite;
  assign M_PADDR   = r_paddr;
  assign M_PWDATA  = r_pwdata;

  // setup -> access (held while PREADY low) -> next setup or idle
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
    end else if (!r_psel || o_done) begin
      if (i_req) begin
        r_psel    <= 1'b1;
        r_penable <= 1'b0;
        r_pwrite  <= i_write;
        r_paddr   <= i_addr;
        r_pwdata  <= i_write ? i_wdata : 32'h0;
      end else begin
        r_psel    <= 1'b0;
        r_penable <= 1'b0;
        r_pwrite  <= 1'b0;
        r_paddr   <= '0;
        r_pwdata  <= '0;
      end
    end else begin
      r_penable <= 1'b1;
    end
  end

endmodule

// File: rtl/apb_uart_sequencer.sv
// Autonomous APB master for one UART: programs BAUDDIV and CTRL, then loops
// polling STAT and servicing RX drain, overrun clear and TX push. Policy
// lives here; the bus handshake lives in apb_xfer_engine.
module apb_uart_sequencer
  import apb_uart_pkg::*;
#(
  parameter logic [19:0] BAUD_DIV  = 20'd434,
  parameter logic [3:0]  CTRL_INIT = 4'b0011
) (
  input  logic        PCLK,
  input  logic        PRESET,
  output logic        M_PSEL,
  output logic        M_PENABLE,
  output logic        M_PWRITE,
  output logic [5:0]  M_PADDR,
  output logic [31:0] M_PWDATA,
  input  logic [31:0] M_PRDATA,
  input  logic        M_PREADY,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        init_done,
  output logic        rx_ovr,
  output logic        tx_ovr,
  input  logic        err_clr
);

  seq_state_e  r_state, w_next, w_cmd;
  logic [3:0]  r_stat;
  logic        r_rx_full, r_init_done, r_rx_ovr, r_tx_ovr;
  logic [7:0]  r_rx_data;
  logic        w_done, w_write, w_set_rx, w_set_tx;
  logic [5:0]  w_addr;
  logic [31:0] w_wdata, w_rdata;

  // Successor of the transfer now in flight; STAT decision uses the word
  // read in the completing POLL cycle and the holding register at that edge.
  always_comb begin
    w_next = ST_POLL;
    case (r_state)
      ST_INIT_BAUD: w_next = ST_INIT_CTRL;
      ST_POLL: begin
        if (w_rdata[STAT_RXAVAIL] && !r_rx_full)       w_next = ST_RD_RXD;
        else if (|w_rdata[STAT_RXOVR:STAT_TXOVR])      w_next = ST_CLR_STAT;
        else if (tx_valid && !w_rdata[STAT_TXFULL])    w_next = ST_WR_TXD;
        else                                           w_next = ST_POLL;
      end
      default: w_next = ST_POLL;
    endcase
  end

  // Command for the transfer the engine launches next (after reset or on done)
  always_comb begin
    w_cmd   = w_done ? w_next : r_state;
    w_addr  = A_STAT;
    w_write = 1'b0;
    w_wdata = 32'h0;
    case (w_cmd)
      ST_INIT_BAUD: begin w_addr = A_BAUDDIV; w_write = 1'b1; w_wdata = {12'h0, BAUD_DIV}; end
      ST_INIT_CTRL: begin w_addr = A_CTRL;    w_write = 1'b1; w_wdata = {28'h0, CTRL_INIT}; end
      ST_RD_RXD:    begin w_addr = A_RXD; end
      ST_CLR_STAT:  begin
        w_addr = A_STAT; w_write = 1'b1;
        w_wdata = {28'h0, w_rdata[STAT_RXOVR:STAT_TXOVR], 2'b00};
      end
      ST_WR_TXD:    begin w_addr = A_TXD;     w_write = 1'b1; w_wdata = {24'h0, tx_data}; end
      default: ;
    endcase
  end

  // The sequencer always has its next transfer lined up.
  apb_xfer_engine u_xfer (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .i_req     (1'b1),
    .i_addr    (w_addr),
    .i_write   (w_write),
    .i_wdata   (w_wdata),
    .o_done    (w_done),
    .o_rdata   (w_rdata),
    .M_PSEL    (M_PSEL),
    .M_PENABLE (M_PENABLE),
    .M_PWRITE  (M_PWRITE),
    .M_PADDR   (M_PADDR),
    .M_PWDATA  (M_PWDATA),
    .M_PRDATA  (M_PRDATA),
    .M_PREADY  (M_PREADY)
  );

  assign w_set_rx = w_done && (r_state == ST_CLR_STAT) && r_stat[STAT_RXOVR];
  assign w_set_tx = w_done && (r_state == ST_CLR_STAT) && r_stat[STAT_TXOVR];

  // Sequencer state, RX holding register and sticky flags (set beats clear)
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state     <= ST_INIT_BAUD;
      r_stat      <= '0;
      r_rx_full   <= 1'b0;
      r_rx_data   <= '0;
      r_init_done <= 1'b0;
      r_rx_ovr    <= 1'b0;
      r_tx_ovr    <= 1'b0;
    end else begin
      if (w_done) r_state <= w_next;
      if (w_done && r_state == ST_POLL) r_stat <= w_rdata[3:0];
      if (w_done && r_state == ST_INIT_CTRL) r_init_done <= 1'b1;
      if (w_done && r_state == ST_RD_RXD) begin
        r_rx_full <= 1'b1;
        r_rx_data <= w_rdata[7:0];
      end else if (r_rx_full && rx_ready) begin
        r_rx_full <= 1'b0;
      end
      r_rx_ovr <= (r_rx_ovr && !err_clr) || w_set_rx;
      r_tx_ovr <= (r_tx_ovr && !err_clr) || w_set_tx;
    end
  end

  assign tx_ready  = w_done && (r_state == ST_WR_TXD);
  assign rx_valid  = r_rx_full;
  assign rx_data   = r_rx_data;
  assign init_done = r_init_done;
  assign rx_ovr    = r_rx_ovr;
  assign tx_ovr    = r_tx_ovr;

endmodule

// File: tb/tb_apb_uart_sequencer.sv
// Bench for apb_uart_sequencer: a behavioural UART register slave, an init
// vector table, directed corner sequences and a randomized stream phase
// scored against byte-order queues.
module tb_apb_uart_sequencer;

  logic        PCLK = 1'b0, PRESET = 1'b1;
  logic        M_PSEL, M_PENABLE, M_PWRITE;
  logic [5:0]  M_PADDR;
  logic [31:0] M_PWDATA, M_PRDATA;
  logic        M_PREADY = 1'b1;
  logic [7:0]  tx_data = 8'h0;
  logic        tx_valid = 1'b0, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready = 1'b0;
  logic        init_done, rx_ovr, tx_ovr, err_clr = 1'b0;

  int total = 0, bad = 0;

  apb_uart_sequencer dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .M_PSEL(M_PSEL), .M_PENABLE(M_PENABLE), .M_PWRITE(M_PWRITE),
    .M_PADDR(M_PADDR), .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .init_done(init_done), .rx_ovr(rx_ovr), .tx_ovr(tx_ovr), .err_clr(err_clr)
  );

  always #5 PCLK = ~PCLK;

  // ---------------- UART slave model ----------------
  logic [7:0] s_rxf [0:15];
  logic [3:0] s_wr = 4'd0, s_rd = 4'd0;
  logic       s_rovr = 1'b0, s_tovr = 1'b0, tb_tx_full = 1'b0;
  logic       inj_rx = 1'b0, inj_rovr = 1'b0, inj_tovr = 1'b0;
  logic [7:0] inj_b = 8'h0;
  logic [3:0] s_stat;

  assign s_stat = {s_rovr, s_tovr, (s_wr != s_rd), tb_tx_full};

  always_comb begin
    M_PRDATA = 32'h0;
    if (M_PADDR == 6'h01) M_PRDATA = {28'h0, s_stat};
    else if (M_PADDR == 6'h03) M_PRDATA = {24'h0, s_rxf[s_rd]};
  end

  always @(posedge PCLK) begin
    if (M_PSEL && M_PENABLE && M_PREADY) begin
      if (M_PWRITE && M_PADDR == 6'h01) begin
        if (M_PWDATA[3]) s_rovr <= 1'b0;
        if (M_PWDATA[2]) s_tovr <= 1'b0;
      end
      if (!M_PWRITE && M_PADDR == 6'h03 && s_wr != s_rd) s_rd <= s_rd + 4'd1;
    end
    if (inj_rx) begin s_rxf[s_wr] <= inj_b; s_wr <= s_wr + 4'd1; end
    if (inj_rovr) s_rovr <= 1'b1;
    if (inj_tovr) s_tovr <= 1'b1;
  end

  // ---------------- helpers ----------------
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic inject(input logic [7:0] b);
    inj_b = b; inj_rx = 1'b1;
    @(posedge PCLK); #1 inj_rx = 1'b0;
  endtask

  task automatic wait_setup(input string nm, input logic [5:0] a, input logic w);
    bit hit = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge PCLK);
      if (M_PSEL && !M_PENABLE && M_PADDR == a && M_PWRITE == w) begin hit = 1; break; end
    end
    check(nm, hit, 1);
  endtask

  // next completing transfer that is not a STAT poll read
  task automatic wait_act(output logic w, output logic [5:0] a, output logic [31:0] d);
    bit hit = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge PCLK);
      if (M_PSEL && M_PENABLE && M_PREADY && !(!M_PWRITE && M_PADDR == 6'h01)) begin hit = 1; break; end
    end
    w = M_PWRITE; a = M_PADDR; d = M_PWDATA;
    check("act_seen", hit, 1);
  endtask

  task automatic wait_rxv(input string nm);
    bit hit = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge PCLK);
      if (rx_valid) begin hit = 1; break; end
    end
    check(nm, hit, 1);
  endtask

  task automatic drain_rx(input string nm, input logic [7:0] exp);
    wait_rxv({nm, "_seen"});
    check(nm, rx_data, exp);
    rx_ready = 1'b1;
    @(negedge PCLK);
    rx_ready = 1'b0;
  endtask

  // ---------------- init vector table ----------------
  typedef struct {
    logic        pready;
    logic        psel, pen, pw;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        idone;
  } vec_t;
  vec_t tv [8];

  // ---------------- random-phase state ----------------
  localparam int NB = 24, NR = 24;
  logic [7:0]  exp_tx [$];
  logic [7:0]  exp_rx [$];
  int          tx_cnt = 0, rx_cnt = 0;
  bit          rnd_done = 0, prev_stall = 0;
  logic [40:0] prev_bus = '0;

  initial begin
    logic        w;
    logic [5:0]  a;
    logic [31:0] d;
    int          n;

    tv[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 6'h04, 32'd434, 1'b0};
    tv[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 6'h04, 32'd434, 1'b0};
    tv[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 6'h00, 32'd3,   1'b0};
    tv[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 6'h00, 32'd3,   1'b0};
    tv[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'h01, 32'd0,   1'b1};
    tv[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 6'h01, 32'd0,   1'b1};
    tv[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'h01, 32'd0,   1'b1};
    tv[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 6'h01, 32'd0,   1'b1};

    // reset state
    repeat (3) @(negedge PCLK);
    check("reset_outs", {M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA, tx_ready,
                         rx_valid, rx_data, init_done, rx_ovr, tx_ovr}, 64'h0);
    PRESET = 1'b0;

    // init sequence, cycle by cycle
    for (int i = 0; i < 8; i++) begin
      @(posedge PCLK); #1 M_PREADY = tv[i].pready;
      @(negedge PCLK);
      check($sformatf("init_c%0d", i + 1),
            {M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA, init_done},
            {tv[i].psel, tv[i].pen, tv[i].pw, tv[i].addr, tv[i].wdata, tv[i].idone});
    end

    // TX at minimum latency: tx_valid raised in a POLL setup cycle
    wait_setup("tx_poll_setup", 6'h01, 1'b0);
    tx_data = 8'h55; tx_valid = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge PCLK); n++;
      if (tx_ready) break;
    end
    check("tx_latency", n, 3);
    check("tx_write", {M_PWRITE, M_PADDR, M_PWDATA}, {1'b1, 6'h02, 32'h55});
    @(posedge PCLK); #1 tx_valid = 1'b0;
    @(negedge PCLK);
    check("tx_pulse", tx_ready, 1'b0);

    // RX held while full; UART overrun cleared; set beats err_clr
    inject(8'hA3);
    wait_rxv("rx_a3_seen");
    check("rx_a3", rx_data, 8'hA3);
    inject(8'h3C);
    repeat (12) @(negedge PCLK);
    check("rx_held", {rx_valid, rx_data}, {1'b1, 8'hA3});
    check("uart_pending", s_wr - s_rd, 4'd1);
    inj_rovr = 1'b1; @(posedge PCLK); #1 inj_rovr = 1'b0;
    wait_act(w, a, d);
    check("clr_rovr", {w, a, d}, {1'b1, 6'h01, 32'h8});
    err_clr = 1'b1;
    @(posedge PCLK); #1 err_clr = 1'b0;
    @(negedge PCLK);
    check("ovr_set_wins", {rx_ovr, tx_ovr}, 2'b10);
    err_clr = 1'b1;
    @(posedge PCLK); #1 err_clr = 1'b0;
    @(negedge PCLK);
    check("ovr_clear", rx_ovr, 1'b0);
    rx_ready = 1'b1;
    @(negedge PCLK);
    rx_ready = 1'b0;
    drain_rx("rx_3c", 8'h3C);
    inj_tovr = 1'b1; @(posedge PCLK); #1 inj_tovr = 1'b0;
    wait_act(w, a, d);
    check("clr_tovr", {w, a, d}, {1'b1, 6'h01, 32'h4});
    @(negedge PCLK);
    check("tx_ovr_set", {rx_ovr, tx_ovr}, 2'b01);
    err_clr = 1'b1;
    @(posedge PCLK); #1 err_clr = 1'b0;

    // RX pending and TX pending in the same POLL: RX first
    tb_tx_full = 1'b1; tx_data = 8'h77; tx_valid = 1'b1;
    repeat (6) @(negedge PCLK);
    wait_setup("prio_poll_setup", 6'h01, 1'b0);
    tb_tx_full = 1'b0;
    inject(8'h42);
    wait_act(w, a, d);
    check("prio_first_rd", {w, a}, {1'b0, 6'h03});
    wait_act(w, a, d);
    check("prio_then_wr", {w, a, d}, {1'b1, 6'h02, 32'h77});
    @(posedge PCLK); #1 tx_valid = 1'b0;
    drain_rx("rx_42", 8'h42);

    // PREADY low for 3 access cycles of a TXD write
    tx_data = 8'h9C; tx_valid = 1'b1;
    wait_setup("wr_setup", 6'h02, 1'b1);
    M_PREADY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge PCLK);
      check($sformatf("stall_%0d", k),
            {M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA, tx_ready},
            {1'b1, 1'b1, 1'b1, 6'h02, 32'h9C, 1'b0});
    end
    @(posedge PCLK); #1 M_PREADY = 1'b1;
    @(negedge PCLK);
    check("stall_done", {M_PADDR, M_PWDATA, tx_ready}, {6'h02, 32'h9C, 1'b1});
    @(posedge PCLK); #1 tx_valid = 1'b0;
    @(negedge PCLK);
    check("stall_pulse", tx_ready, 1'b0);

    // reset during a stalled RXD read: bus drops, init reruns, byte kept
    inject(8'h5A);
    wait_setup("rd_setup", 6'h03, 1'b0);
    M_PREADY = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b1;
    @(negedge PCLK);
    check("rst_mid", {M_PSEL, M_PENABLE, rx_valid, init_done}, 4'b0);
    PRESET = 1'b0; M_PREADY = 1'b1;
    @(negedge PCLK);
    check("reinit", {M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA},
          {1'b1, 1'b0, 1'b1, 6'h04, 32'd434});
    drain_rx("rx_5a", 8'h5A);
    check("reinit_done", init_done, 1'b1);

    // randomized stream traffic with random PREADY / rx_ready
    fork
      begin : producer
        for (int i = 0; i < NB; i++) begin
          bit got = 0;
          logic [7:0] b;
          b = 8'($urandom);
          exp_tx.push_back(b);
          tx_data = b; tx_valid = 1'b1;
          for (int k = 0; k < 400; k++) begin
            @(negedge PCLK);
            if (tx_ready) begin got = 1; break; end
          end
          @(posedge PCLK); #1 tx_valid = 1'b0;
          check("rnd_tx_accept", got, 1);
          repeat ($urandom_range(0, 6)) @(posedge PCLK);
          #1;
        end
      end
      begin : injector
        for (int i = 0; i < NR; i++) begin
          logic [7:0] b;
          repeat ($urandom_range(5, 30)) @(posedge PCLK);
          #1;
          b = 8'($urandom);
          exp_rx.push_back(b);
          inject(b);
        end
      end
      begin : ctrl
        for (int c = 0; c < 8000 && !rnd_done; c++) begin
          @(posedge PCLK); #1;
          M_PREADY = ($urandom_range(0, 3) != 0);
          rx_ready = ($urandom_range(0, 1) != 0);
        end
      end
      begin : mon
        for (int c = 0; c < 8000 && !rnd_done; c++) begin
          logic [40:0] cur;
          @(negedge PCLK);
          cur = {M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA};
          if (prev_stall) check("rnd_stall_hold", cur, prev_bus);
          prev_stall = M_PSEL && M_PENABLE && !M_PREADY;
          prev_bus = cur;
          if (!M_PSEL) check("rnd_idle_bus", cur, 41'h0);
          if (tx_ready) begin
            check("rnd_tx_q", exp_tx.size() != 0, 1);
            if (exp_tx.size() != 0) begin
              logic [7:0] e;
              e = exp_tx.pop_front();
              check("rnd_tx", {M_PWRITE, M_PADDR, M_PWDATA}, {1'b1, 6'h02, 24'h0, e});
              tx_cnt++;
            end
          end
          if (rx_valid && rx_ready) begin
            check("rnd_rx_q", exp_rx.size() != 0, 1);
            if (exp_rx.size() != 0) begin
              logic [7:0] e;
              e = exp_rx.pop_front();
              check("rnd_rx", rx_data, e);
              rx_cnt++;
            end
          end
        end
      end
      begin : stopper
        for (int c = 0; c < 8000; c++) begin
          @(negedge PCLK);
          if (tx_cnt == NB && rx_cnt == NR) break;
        end
        rnd_done = 1;
      end
    join
    M_PREADY = 1'b1; rx_ready = 1'b0;
    check("rnd_tx_cnt", tx_cnt, NB);
    check("rnd_rx_cnt", rx_cnt, NR);
    check("rnd_flags", {rx_ovr, tx_ovr}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
